// File: rtl/orion_merge_n_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | orion_merge_pkg                                                            |
// | Shared types and helpers for the orion merge / round-robin arbiter blocks. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package orion_merge_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   // Index width that never collapses to zero bits.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Two-phase channel holds a token when request and acknowledge phases differ.
   function automatic logic tok(input logic req, input logic ack);
      return req ^ ack;
   endfunction

endpackage
`default_nettype wire

// File: rtl/orion_merge_n_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | orion_rr_arbiter                                                           |
// | Combinational round-robin pick: first request at or after ptr, wrapping.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module orion_rr_arbiter
   import orion_merge_pkg::*;
#(
   parameter int NUM_IN = 2
) (
   input  logic [NUM_IN-1:0]            req,
   input  logic [idx_width(NUM_IN)-1:0] ptr,
   output logic [NUM_IN-1:0]            grant,
   output logic [idx_width(NUM_IN)-1:0] idx,
   output logic                         valid
);

   localparam int IDX_W = idx_width(NUM_IN);

   int               cand;
   logic [IDX_W-1:0] c_idx;

   // Scan offsets from farthest to nearest so the nearest request overwrites.
   always_comb begin
      grant = '0;
      idx   = '0;
      valid = 1'b0;
      cand  = 0;
      c_idx = '0;
      for (int k = NUM_IN - 1; k >= 0; k--) begin
         cand = int'(ptr) + k;
         if (cand >= NUM_IN) begin
            cand = cand - NUM_IN;
         end
         c_idx = IDX_W'(cand);
         if (req[c_idx]) begin
            grant        = '0;
            grant[c_idx] = 1'b1;
            idx          = c_idx;
            valid        = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/orion_merge_n.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | orion_merge_n                                                              |
// | Clocked N-input two-phase bundled-data merge with round-robin arbitration. |
// | Optional ORION_MERGE_N_SYNC_EN: 2-flop synchronisers on in_req / out_ack.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module orion_merge_n
   import orion_merge_pkg::*;
#(
   parameter int                NUM_IN       = 2,
   parameter int                WIDTH        = 1,
   parameter logic [NUM_IN-1:0] IN_ACK_INIT  = '0,
   parameter logic              OUT_REQ_INIT = 1'b0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_IN-1:0]            in_req,
   output logic [NUM_IN-1:0]            in_ack,
   input  logic [NUM_IN*WIDTH-1:0]      in_data,
   output logic                         out_req,
   input  logic                         out_ack,
   output logic [WIDTH-1:0]             out_data,
   output logic [idx_width(NUM_IN)-1:0] grant_idx,
   output logic                         busy
);

   localparam int IDX_W = idx_width(NUM_IN);

   logic [NUM_IN-1:0] req_s;
   logic              ack_s;
   logic [NUM_IN-1:0] token;
   logic              bubble;
   logic [NUM_IN-1:0] arb_grant;
   logic [IDX_W-1:0]  arb_idx;
   logic              arb_valid;
   logic [IDX_W-1:0]  rr_ptr;
   logic [IDX_W-1:0]  ptr_nxt;
   logic [NUM_IN-1:0] rel_mask;
   logic [WIDTH-1:0]  sel_data;
   logic              do_grant;
   logic              do_release;
   state_t            state;
   state_t            state_nxt;

`ifdef ORION_MERGE_N_SYNC_EN
   logic [NUM_IN-1:0] req_m;
   logic              ack_m;

   always_ff @(posedge clk) begin
      if (reset) begin
         req_m <= IN_ACK_INIT;
         req_s <= IN_ACK_INIT;
         ack_m <= OUT_REQ_INIT;
         ack_s <= OUT_REQ_INIT;
      end else begin
         req_m <= in_req;
         req_s <= req_m;
         ack_m <= out_ack;
         ack_s <= ack_m;
      end
   end
`else
   assign req_s = in_req;
   assign ack_s = out_ack;
`endif

   for (genvar i = 0; i < NUM_IN; i++) begin : g_tok
      assign token[i] = tok(req_s[i], in_ack[i]);
   end

   assign bubble = ~tok(ack_s, out_req);

   orion_rr_arbiter #(
      .NUM_IN (NUM_IN)
   ) u_arb (
      .req   (token),
      .ptr   (rr_ptr),
      .grant (arb_grant),
      .idx   (arb_idx),
      .valid (arb_valid)
   );

   // One-hot AND-OR mux: only the granted channel can reach out_data.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (arb_grant[i]) begin
            sel_data = sel_data | in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   assign ptr_nxt  = (grant_idx == IDX_W'(NUM_IN - 1)) ? '0 : grant_idx + 1'b1;
   assign rel_mask = {{(NUM_IN-1){1'b0}}, 1'b1} << grant_idx;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (arb_valid && bubble) state_nxt = SEND;
         SEND:    if (bubble)              state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy       = (state == SEND);
      do_grant   = (state == IDLE) && arb_valid && bubble;
      do_release = (state == SEND) && bubble;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         in_ack    <= IN_ACK_INIT;
         out_req   <= OUT_REQ_INIT;
         out_data  <= '0;
         grant_idx <= '0;
         rr_ptr    <= '0;
      end else begin
         if (do_grant) begin
            out_data  <= sel_data;
            out_req   <= ~out_req;
            grant_idx <= arb_idx;
         end
         // Acknowledge the input only once the output token has been consumed.
         if (do_release) begin
            in_ack <= in_ack ^ rel_mask;
            rr_ptr <= ptr_nxt;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_orion_merge_n.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_orion_merge_n                                                           |
// | Randomised bench for orion_merge_n (NUM_IN=4 and NUM_IN=3 instances).      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_orion_merge_n;

`ifdef ORION_MERGE_N_SYNC_EN
   localparam int LAT  = 3;
   localparam bit SYNC = 1'b1;
`else
   localparam int LAT  = 1;
   localparam bit SYNC = 1'b0;
`endif
   localparam logic [3:0] INIT_A0 = 4'b0000;
   localparam logic [2:0] INIT_A1 = 3'b101;
   localparam logic       ORI0    = 1'b0;
   localparam logic       ORI1    = 1'b1;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // stimulus
   logic [3:0] t_req  [2];
   logic [7:0] t_data [2][4];
   logic       t_ack  [2];

   // observed
   logic [3:0] o_ack   [2];
   logic       o_oreq  [2];
   logic [7:0] o_odata [2];
   logic [1:0] o_gidx  [2];
   logic       o_busy  [2];

   logic [31:0] data0;
   logic [23:0] data1;
   logic [2:0]  ia1;
   logic [3:0]  ia0;

   assign data0 = {t_data[0][3], t_data[0][2], t_data[0][1], t_data[0][0]};
   assign data1 = {t_data[1][2], t_data[1][1], t_data[1][0]};
   assign o_ack[0] = ia0;
   assign o_ack[1] = {1'b0, ia1};

   orion_merge_n #(.NUM_IN(4), .WIDTH(8), .IN_ACK_INIT(INIT_A0), .OUT_REQ_INIT(ORI0)) dut4 (
      .clk(clk), .reset(reset), .in_req(t_req[0]), .in_ack(ia0), .in_data(data0),
      .out_req(o_oreq[0]), .out_ack(t_ack[0]), .out_data(o_odata[0]),
      .grant_idx(o_gidx[0]), .busy(o_busy[0]));

   orion_merge_n #(.NUM_IN(3), .WIDTH(8), .IN_ACK_INIT(INIT_A1), .OUT_REQ_INIT(ORI1)) dut3 (
      .clk(clk), .reset(reset), .in_req(t_req[1][2:0]), .in_ack(ia1), .in_data(data1),
      .out_req(o_oreq[1]), .out_ack(t_ack[1]), .out_data(o_odata[1]),
      .grant_idx(o_gidx[1]), .busy(o_busy[1]));

   // reference model state
   logic [3:0] m_ack   [2];
   logic       m_oreq  [2];
   logic [7:0] m_odata [2];
   int         m_gidx  [2];
   int         m_owner [2];
   int         m_ptr   [2];
   logic [3:0] p1_req  [2];
   logic [3:0] p2_req  [2];
   logic       p1_ack  [2];
   logic       p2_ack  [2];

   function automatic int nch(input int d);
      return (d == 0) ? 4 : 3;
   endfunction

   function automatic logic [3:0] iack(input int d);
      return (d == 0) ? INIT_A0 : {1'b0, INIT_A1};
   endfunction

   function automatic logic iore(input int d);
      return (d == 0) ? ORI0 : ORI1;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge(input int d);
      logic [3:0] rq;
      logic       ak;
      int         g;
      int         c;
      if (reset) begin
         m_ack[d]   = iack(d);
         m_oreq[d]  = iore(d);
         m_odata[d] = 8'h00;
         m_gidx[d]  = 0;
         m_owner[d] = -1;
         m_ptr[d]   = 0;
         p1_req[d]  = iack(d);
         p2_req[d]  = iack(d);
         p1_ack[d]  = iore(d);
         p2_ack[d]  = iore(d);
      end else begin
         rq = SYNC ? p2_req[d] : t_req[d];
         ak = SYNC ? p2_ack[d] : t_ack[d];
         if (m_owner[d] < 0) begin
            if (ak == m_oreq[d]) begin
               g = -1;
               for (int k = 0; k < nch(d); k++) begin
                  c = (m_ptr[d] + k) % nch(d);
                  if (g < 0 && rq[c] != m_ack[d][c]) g = c;
               end
               if (g >= 0) begin
                  m_odata[d] = t_data[d][g];
                  m_oreq[d]  = ~m_oreq[d];
                  m_gidx[d]  = g;
                  m_owner[d] = g;
               end
            end
         end else if (ak == m_oreq[d]) begin
            m_ack[d][m_owner[d]] = ~m_ack[d][m_owner[d]];
            m_ptr[d]   = (m_owner[d] + 1) % nch(d);
            m_owner[d] = -1;
         end
         p2_req[d] = p1_req[d];
         p1_req[d] = t_req[d];
         p2_ack[d] = p1_ack[d];
         p1_ack[d] = t_ack[d];
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      #1;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("d%0d_in_ack", d),    32'(o_ack[d]),   32'(m_ack[d]));
         check($sformatf("d%0d_out_req", d),   32'(o_oreq[d]),  32'(m_oreq[d]));
         check($sformatf("d%0d_out_data", d),  32'(o_odata[d]), 32'(m_odata[d]));
         check($sformatf("d%0d_grant_idx", d), 32'(o_gidx[d]),  32'(m_gidx[d]));
         check($sformatf("d%0d_busy", d),      32'(o_busy[d]),  32'(m_owner[d] >= 0));
      end
   endtask

   task automatic wait_oreq(input int d, output int n);
      logic prev;
      prev = o_oreq[d];
      n = 0;
      while (o_oreq[d] == prev && n < 12) begin
         step();
         n++;
      end
      if (o_oreq[d] == prev) check("out_req_timeout", 32'(o_oreq[d]), 32'(~prev));
   endtask

   task automatic wait_iack(input int d, input int ch, output int n);
      logic prev;
      prev = o_ack[d][ch];
      n = 0;
      while (o_ack[d][ch] == prev && n < 12) begin
         step();
         n++;
      end
      if (o_ack[d][ch] == prev) check("in_ack_timeout", 32'(o_ack[d][ch]), 32'(~prev));
   endtask

   task automatic give_ack(input int d);
      t_ack[d] = m_oreq[d];
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      int n;
      int exp_ptr;
      int g;
      logic [3:0] ack_hold;

      t_req[0] = INIT_A0;
      t_req[1] = {1'b0, INIT_A1};
      t_ack[0] = ORI0;
      t_ack[1] = 1'b0;            // out of phase with OUT_REQ_INIT: no bubble yet
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 4; i++) t_data[d][i] = 8'h00;
      reset = 1'b1;
      repeat (3) step();
      reset = 1'b0;
      repeat (20) step();

      // NUM_IN=3 instance: token must wait for a bubble after reset
      t_data[1][1] = 8'h3C;
      t_req[1][1]  = ~t_req[1][1];
      repeat (6) step();
      check("d1_wait_bubble_busy", 32'(o_busy[1]), 32'd0);
      t_ack[1] = 1'b1;
      wait_oreq(1, n);
      check("d1_grant_idx", 32'(o_gidx[1]), 32'd1);
      check("d1_grant_data", 32'(o_odata[1]), 32'h3C);
      give_ack(1);
      wait_iack(1, 1, n);
      check("d1_ack_latency", 32'(n), 32'(LAT));

      // wrap: ptr sits at 2, tokens on 2 and 0 -> 2 then 0
      t_data[1][0] = 8'hC0;
      t_data[1][2] = 8'hC2;
      t_req[1] = t_req[1] ^ 4'b0101;
      for (int k = 0; k < 2; k++) begin
         g = (2 + k) % 3;
         wait_oreq(1, n);
         check("d1_wrap_idx", 32'(o_gidx[1]), 32'(g));
         check("d1_wrap_data", 32'(o_odata[1]), 32'(8'hC0 + g));
         give_ack(1);
         wait_iack(1, g, n);
      end

      // single transfer on channel 2
      t_data[0][2] = 8'hA5;
      t_req[0][2]  = ~t_req[0][2];
      wait_oreq(0, n);
      check("d0_req_latency", 32'(n), 32'(LAT));
      check("d0_single_data", 32'(o_odata[0]), 32'hA5);
      check("d0_single_idx", 32'(o_gidx[0]), 32'd2);
      give_ack(0);
      wait_iack(0, 2, n);
      check("d0_ack_latency", 32'(n), 32'(LAT));
      check("d0_single_idle", 32'(o_busy[0]), 32'd0);

      // simultaneous tokens, twice; round robin starts after last grant (2)
      exp_ptr = 3;
      for (int rep = 0; rep < 2; rep++) begin
         for (int i = 0; i < 4; i++) t_data[0][i] = 8'(8'h10 * (rep + 1) + i);
         t_req[0] = t_req[0] ^ 4'hF;
         for (int k = 0; k < 4; k++) begin
            g = (exp_ptr + k) % 4;
            wait_oreq(0, n);
            check("d0_rr_order", 32'(o_gidx[0]), 32'(g));
            check("d0_rr_data", 32'(o_odata[0]), 32'(t_data[0][g]));
            give_ack(0);
            wait_iack(0, g, n);
         end
      end

      // backpressure: hold out_ack, new token must stay pending
      t_data[0][1] = 8'h77;
      t_req[0][1]  = ~t_req[0][1];
      wait_oreq(0, n);
      ack_hold = m_ack[0];
      t_data[0][0] = 8'h55;
      t_req[0][0]  = ~t_req[0][0];
      repeat (10) step();
      check("d0_bp_busy", 32'(o_busy[0]), 32'd1);
      check("d0_bp_data", 32'(o_odata[0]), 32'h77);
      check("d0_bp_idx", 32'(o_gidx[0]), 32'd1);
      check("d0_bp_in_ack", 32'(o_ack[0]), 32'(ack_hold));
      give_ack(0);
      wait_iack(0, 1, n);
      wait_oreq(0, n);
      check("d0_bp_next_idx", 32'(o_gidx[0]), 32'd0);
      check("d0_bp_next_data", 32'(o_odata[0]), 32'h55);
      give_ack(0);
      wait_iack(0, 0, n);

      // reset while SEND
      t_data[0][3] = 8'h99;
      t_req[0][3]  = ~t_req[0][3];
      wait_oreq(0, n);
      check("d0_pre_reset_busy", 32'(o_busy[0]), 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      t_ack[0] = ORI0;
      t_ack[1] = ORI1;
      check("d0_rst_in_ack", 32'(o_ack[0]), 32'(INIT_A0));
      check("d0_rst_out_req", 32'(o_oreq[0]), 32'(ORI0));
      check("d0_rst_data", 32'(o_odata[0]), 32'd0);
      check("d0_rst_busy", 32'(o_busy[0]), 32'd0);

      // randomised traffic with occasional reset
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < nch(d); i++) begin
               if (t_req[d][i] == m_ack[d][i] && $urandom_range(0, 3) == 0) begin
                  t_data[d][i] = 8'($urandom);
                  t_req[d][i]  = ~t_req[d][i];
               end
            end
            if (t_ack[d] != m_oreq[d] && $urandom_range(0, 2) == 0) give_ack(d);
         end
         reset = ($urandom_range(0, 499) == 0);
         step();
      end
      reset = 1'b0;
      repeat (4) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
